// File: rtl/bram_burst_port.sv
// Single-port BRAM slave with configurable access delay and FIXED/INCR/WRAP bursts.
// Define BRAM_BURST_PORT_WRAP_EN to enable WRAP bursts (burst=10); otherwise WRAP behaves as INCR.
module bram_burst_port #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH_LOG2 = 18,
    parameter int DELAY      = 2,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrobe,
    input  logic [1:0]              burst,
    input  logic [LEN_WIDTH-1:0]    len,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    ready,
    output logic                    last
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFS    = $clog2(NBYTES);
    localparam int WORDS  = 1 << DEPTH_LOG2;
    localparam logic [LEN_WIDTH:0] IDX_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;
    typedef enum logic [1:0] {M_FIXED, M_INCR, M_WRAP} mode_t;

    state_t                  state;
    mode_t                   mode;
    logic [DEPTH_LOG2-1:0]   w0;
    logic [DEPTH_LOG2-1:0]   wr_word;
    logic [DEPTH_LOG2-1:0]   rd_word;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    k;
    logic [7:0]              cnt;
    logic                    is_write;
    logic                    primed;
    logic                    we;
    logic [DATA_WIDTH-1:0]   mem_q;
    logic [DATA_WIDTH-1:0]   mem [WORDS];

    // Upper address bits alias onto the array; byte offset bits are don't-care.
    logic unused_addr;
    assign unused_addr = ^{addr[ADDR_WIDTH-1:OFS+DEPTH_LOG2], addr[OFS-1:0]};

    function automatic mode_t decode_mode(input logic [1:0] b, input logic [LEN_WIDTH-1:0] l);
        mode_t m;
        m = M_INCR;
        if (b == 2'b00) m = M_FIXED;
`ifdef BRAM_BURST_PORT_WRAP_EN
        else if (b == 2'b10 && (l == LEN_WIDTH'(1) || l == LEN_WIDTH'(3) ||
                                l == LEN_WIDTH'(7) || l == LEN_WIDTH'(15)))
            m = M_WRAP;
`else
        if (l == '0) m = m;
`endif
        return m;
    endfunction

    // Word address of beat j for the latched burst; WRAP window mask equals len (N-1).
    function automatic logic [DEPTH_LOG2-1:0] beat_word(input logic [LEN_WIDTH:0] j);
        logic [DEPTH_LOG2-1:0] inc;
        logic [DEPTH_LOG2-1:0] res;
        inc = w0 + DEPTH_LOG2'(j);
        res = inc;
        if (mode == M_FIXED) res = w0;
`ifdef BRAM_BURST_PORT_WRAP_EN
        else if (mode == M_WRAP)
            res = (w0 & ~DEPTH_LOG2'(len_q)) | (inc & DEPTH_LOG2'(len_q));
`endif
        return res;
    endfunction

    // The first BURST cycle primes the read pipeline with beat 0; afterwards fetch one beat ahead.
    assign rd_word = beat_word(primed ? ({1'b0, k} + IDX_ONE) : {1'b0, k});
    assign we      = !reset && state == S_BURST && ready && is_write && valid;

    // NOTE: the array has no reset so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        mem_q <= mem[rd_word];
        if (we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wstrobe[b]) mem[wr_word][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // NOTE: every register here is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            mode     <= M_INCR;
            w0       <= '0;
            wr_word  <= '0;
            len_q    <= '0;
            k        <= '0;
            cnt      <= '0;
            is_write <= 1'b0;
            primed   <= 1'b0;
            ready    <= 1'b0;
            last     <= 1'b0;
            rdata    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready <= 1'b0;
                    last  <= 1'b0;
                    if (valid) begin
                        w0       <= addr[OFS+DEPTH_LOG2-1:OFS];
                        len_q    <= len;
                        mode     <= decode_mode(burst, len);
                        is_write <= |wstrobe;
                        k        <= '0;
                        cnt      <= '0;
                        primed   <= 1'b0;
                        state    <= (DELAY == 0) ? S_BURST : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!valid) begin
                        state <= S_IDLE;
                    end else if (9'(cnt) + 9'd1 >= 9'(DELAY)) begin
                        state <= S_BURST;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_BURST: begin
                    if (!valid) begin
                        state <= S_IDLE;
                        ready <= 1'b0;
                        last  <= 1'b0;
                    end else if (ready && last) begin
                        state <= S_DONE;
                        ready <= 1'b0;
                        last  <= 1'b0;
                    end else if (!primed) begin
                        primed <= 1'b1;
                    end else begin
                        ready   <= 1'b1;
                        last    <= (k == len_q);
                        wr_word <= beat_word({1'b0, k});
                        if (!is_write) rdata <= mem_q;
                        k       <= k + LEN_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    ready <= 1'b0;
                    last  <= 1'b0;
                    if (!valid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_burst_port.sv
// Directed testbench for bram_burst_port (default parameters, DELAY=2).
module tb_bram_burst_port;

    localparam int DELAY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrobe;
    logic [1:0]  burst;
    logic [7:0]  len;
    logic [63:0] rdata;
    logic        ready;
    logic        last;

    int tests = 0;
    int fails = 0;

    logic [63:0] wbuf [16];
    logic [63:0] rbuf [16];

    bram_burst_port #(.DELAY(DELAY)) dut (
        .clk(clk), .reset(reset), .valid(valid), .addr(addr), .wdata(wdata),
        .wstrobe(wstrobe), .burst(burst), .len(len),
        .rdata(rdata), .ready(ready), .last(last)
    );

    always #5 clk = ~clk;

    // Runs one transaction; abort_at >= 0 drops valid when that beat index becomes ready.
    task automatic xfer(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b,
                        input logic [7:0] s, input int abort_at);
        int beats;
        int cyc;
        bit done;
        @(negedge clk);
        valid = 1'b1; addr = a; len = l; burst = b; wstrobe = s; wdata = wbuf[0];
        beats = 0; cyc = 0; done = 1'b0;
        while (!done) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc > 300) begin
                tests++; fails++;
                $display("FAIL timeout addr=%h: no completion within 300 cycles", a);
                done = 1'b1;
            end else if (ready) begin
                if (beats == abort_at) begin
                    valid = 1'b0;
                    @(posedge clk); #1;
                    tests++;
                    if (ready !== 1'b0 || last !== 1'b0) begin
                        fails++;
                        $display("FAIL abort_idle ready=%b last=%b expected 0 0", ready, last);
                    end
                    done = 1'b1;
                end else begin
                    if (beats == 0) begin
                        tests++;
                        if (cyc != DELAY + 3) begin
                            fails++;
                            $display("FAIL first_ready_latency got edge %0d expected %0d", cyc, DELAY + 3);
                        end
                    end
                    tests++;
                    if (last !== (beats == int'(l))) begin
                        fails++;
                        $display("FAIL last_flag beat %0d got %b expected %b", beats, last, beats == int'(l));
                    end
                    rbuf[beats] = rdata;
                    wdata = wbuf[beats];
                    beats++;
                    if (beats > int'(l)) begin
                        @(posedge clk); #1;
                        tests++;
                        if (ready !== 1'b0) begin
                            fails++;
                            $display("FAIL done_ready got %b expected 0", ready);
                        end
                        valid = 1'b0;
                        @(posedge clk); #1;
                        done = 1'b1;
                    end
                end
            end
        end
        valid = 1'b0;
        wstrobe = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid = 1'b1; addr = 64'h100; wdata = '0;
        wstrobe = 8'h00; burst = 2'b01; len = 8'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (ready !== 1'b0 || last !== 1'b0 || rdata !== 64'h0) begin
                fails++;
                $display("FAIL reset_outputs ready=%b last=%b rdata=%h expected 0", ready, last, rdata);
            end
        end
        valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_incr();
        wbuf[0] = 64'hAAAA_0000_0000_000A; wbuf[1] = 64'hBBBB_0000_0000_000B;
        wbuf[2] = 64'hCCCC_0000_0000_000C; wbuf[3] = 64'hDDDD_0000_0000_000D;
        xfer(64'h100, 8'd3, 2'b01, 8'hFF, -1);
        xfer(64'h100, 8'd3, 2'b01, 8'h00, -1);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rbuf[i] !== wbuf[i]) begin
                fails++;
                $display("FAIL incr_read beat %0d got %h expected %h", i, rbuf[i], wbuf[i]);
            end
        end
        xfer(64'h118, 8'd0, 2'b00, 8'h00, -1);
        tests++;
        if (rbuf[0] !== 64'hDDDD_0000_0000_000D) begin
            fails++;
            $display("FAIL word_0x23 got %h expected %h", rbuf[0], 64'hDDDD_0000_0000_000D);
        end
    endtask

    task automatic test_fixed();
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        xfer(64'h200, 8'd0, 2'b01, 8'hFF, -1);
        wbuf[0] = 64'h1; wbuf[1] = 64'h2; wbuf[2] = 64'h3;
        xfer(64'h200, 8'd2, 2'b00, 8'h0F, -1);
        xfer(64'h200, 8'd0, 2'b01, 8'h00, -1);
        tests++;
        if (rbuf[0] !== 64'hFFFF_FFFF_0000_0003) begin
            fails++;
            $display("FAIL fixed_strobe got %h expected %h", rbuf[0], 64'hFFFF_FFFF_0000_0003);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] exp_w [4];
        for (int i = 0; i < 6; i++) wbuf[i] = 64'h1000 + 64'(i + 4);
        xfer(64'h20, 8'd5, 2'b01, 8'hFF, -1);
`ifdef BRAM_BURST_PORT_WRAP_EN
        exp_w[0] = 64'h1006; exp_w[1] = 64'h1007; exp_w[2] = 64'h1004; exp_w[3] = 64'h1005;
`else
        exp_w[0] = 64'h1006; exp_w[1] = 64'h1007; exp_w[2] = 64'h1008; exp_w[3] = 64'h1009;
`endif
        xfer(64'h30, 8'd3, 2'b10, 8'h00, -1);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rbuf[i] !== exp_w[i]) begin
                fails++;
                $display("FAIL wrap_read beat %0d got %h expected %h", i, rbuf[i], exp_w[i]);
            end
        end
        xfer(64'h30, 8'd3, 2'b11, 8'h00, -1);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rbuf[i] !== 64'h1006 + 64'(i)) begin
                fails++;
                $display("FAIL reserved_incr beat %0d got %h expected %h", i, rbuf[i], 64'h1006 + 64'(i));
            end
        end
    endtask

    task automatic test_top_wrap();
        wbuf[0] = 64'h7070_7070_0000_0001; wbuf[1] = 64'h0F0F_0F0F_0000_0002;
        xfer(64'h1F_FFF8, 8'd1, 2'b01, 8'hFF, -1);
        xfer(64'h1F_FFF8, 8'd1, 2'b01, 8'h00, -1);
        tests++;
        if (rbuf[0] !== wbuf[0] || rbuf[1] !== wbuf[1]) begin
            fails++;
            $display("FAIL top_wrap got %h %h expected %h %h", rbuf[0], rbuf[1], wbuf[0], wbuf[1]);
        end
        xfer(64'hABCD_0000_0000_0000, 8'd0, 2'b01, 8'h00, -1);
        tests++;
        if (rbuf[0] !== wbuf[1]) begin
            fails++;
            $display("FAIL addr_alias got %h expected %h", rbuf[0], wbuf[1]);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 8; i++) wbuf[i] = 64'h5000 + 64'(i);
        xfer(64'h8, 8'd7, 2'b01, 8'hFF, -1);
        for (int i = 0; i < 8; i++) wbuf[i] = 64'h6000 + 64'(i);
        xfer(64'h8, 8'd7, 2'b01, 8'hFF, 2);
        xfer(64'h8, 8'd7, 2'b01, 8'h00, -1);
        for (int i = 0; i < 8; i++) begin
            logic [63:0] exp_v;
            exp_v = (i < 2) ? 64'h6000 + 64'(i) : 64'h5000 + 64'(i);
            tests++;
            if (rbuf[i] !== exp_v) begin
                fails++;
                $display("FAIL abort_contents word %0d got %h expected %h", i + 1, rbuf[i], exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_fixed();
        test_wrap();
        test_top_wrap();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
